// File: rtl/gemm_operand_loader_if.sv
// Stream-in / SRAM-write bundle for the GeMM operand loader.
// The loader is the slave on the stream side and drives the SRAM write port.
interface gemm_operand_loader_if #(
    parameter int InDataWidth = 8,
    parameter int InMemWidth  = 128,
    parameter int AddrWidth   = 12
);
    logic [InDataWidth-1:0] s_data_i;
    logic                   s_valid_i;
    logic                   s_ready_o;
    logic [AddrWidth-1:0]   sram_addr_o;
    logic [InMemWidth-1:0]  sram_wdata_o;
    logic                   sram_we_o;

    modport slave (
        input  s_data_i, s_valid_i,
        output s_ready_o, sram_addr_o, sram_wdata_o, sram_we_o
    );

    modport master (
        output s_data_i, s_valid_i,
        input  s_ready_o, sram_addr_o, sram_wdata_o, sram_we_o
    );
endinterface

// File: rtl/gemm_operand_loader.sv
// Packs a byte stream into InMemWidth words and writes them to the operand
// SRAM at consecutive, wrapping addresses.
module gemm_operand_loader #(
    parameter int InDataWidth = 8,
    parameter int InMemWidth  = 128,
    parameter int AddrWidth   = 12,
    parameter int CountWidth  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  base_addr_i,
    input  logic [CountWidth-1:0] num_words_i,
    gemm_operand_loader_if.slave  bus,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int ElemsPerWord = InMemWidth / InDataWidth;
    localparam int EW = (ElemsPerWord > 1) ? $clog2(ElemsPerWord) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                                     r_state, w_next;
    logic [AddrWidth-1:0]                       r_base;
    logic [CountWidth-1:0]                      r_num;
    logic [EW-1:0]                              r_elem_cnt;
    logic [CountWidth-1:0]                      r_word_cnt;
    logic [ElemsPerWord-1:0][InDataWidth-1:0]   r_pack;
    logic [ElemsPerWord-1:0][InDataWidth-1:0]   w_word;
    logic [AddrWidth-1:0]                       r_addr;
    logic [InMemWidth-1:0]                      r_wdata;
    logic                                       r_we;
    logic                                       w_beat;
    logic                                       w_word_end;
    logic                                       w_last_word;

    assign w_beat      = (r_state == S_LOAD) && bus.s_valid_i;
    assign w_word_end  = w_beat && (r_elem_cnt == EW'(ElemsPerWord - 1));
    assign w_last_word = (r_word_cnt == r_num - CountWidth'(1));

    // Current beat merged into its lane so a completing word includes it.
    for (genvar e = 0; e < ElemsPerWord; e++) begin : g_lane
        assign w_word[e] = (w_beat && (r_elem_cnt == EW'(e))) ? bus.s_data_i : r_pack[e];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = (num_words_i == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (w_word_end && w_last_word) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_num      <= '0;
            r_elem_cnt <= '0;
            r_word_cnt <= '0;
            r_pack     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == S_IDLE && start_i) begin
                r_base     <= base_addr_i;
                r_num      <= num_words_i;
                r_elem_cnt <= '0;
                r_word_cnt <= '0;
                r_pack     <= '0;
            end
            if (w_beat) begin
                r_pack     <= w_word;
                r_elem_cnt <= w_word_end ? '0 : r_elem_cnt + EW'(1);
            end
            if (w_word_end) begin
                r_we       <= 1'b1;
                r_wdata    <= w_word;
                r_addr     <= r_base + AddrWidth'(r_word_cnt);
                r_word_cnt <= r_word_cnt + CountWidth'(1);
            end
        end
    end

    assign bus.s_ready_o    = (r_state == S_LOAD);
    assign bus.sram_addr_o  = r_addr;
    assign bus.sram_wdata_o = r_wdata;
    assign bus.sram_we_o    = r_we;
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = (r_state == S_DONE);
endmodule
